ps2_key_decoder: RTL and testbench

- Receives PS/2 keyboard frames on kclk/kdata and decodes set-2 make/break sequences into held-key flags for game control.
- Sits directly upstream of the game logic inside top_vga, in the 65 MHz pixel-clock domain.
- Host never drives the PS/2 lines; the block is receive-only.

---
 rtl/ps2_key_decoder.sv | 170 +++++++++++++++++
 tb/tb_ps2_key_decoder.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/ps2_key_decoder.sv
// Receive-only PS/2 set-2 keyboard decoder producing held-key flags for the arrows and space.
// Optional build macro: PS2_PARITY_CHECK_EN (when defined, bad odd-parity frames are rejected).
module ps2_key_decoder #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 130000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       kclk,
  input  logic       kdata,
  output logic [7:0] scan_code,
  output logic       scan_valid,
  output logic       frame_err,
  output logic       key_left,
  output logic       key_right,
  output logic       key_up,
  output logic       key_down,
  output logic       key_space
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} frame_state_t;
  typedef enum logic [1:0] {BASE, EXT, BRK, EXT_BRK} seq_state_t;

  logic [1:0]    kclk_sync, kdata_sync;
  logic          filt_reg;
  logic [FW-1:0] filt_cnt_reg;
  logic          ks, kd, fall;

  frame_state_t  state_reg, state_next;
  logic [2:0]    bit_cnt_reg, bit_cnt_next;
  logic [7:0]    shift_reg, shift_next;
  logic          par_reg, par_next;
  logic [TW-1:0] tmo_reg, tmo_next;
  logic          frame_ok, frame_bad, parity_ok;

  seq_state_t    seq_reg, seq_next;
  logic [4:0]    flags_reg, flags_next;  // {left, right, up, down, space}
  logic          ext, make;

  assign ks = kclk_sync[1];
  assign kd = kdata_sync[1];

  // Idle bus level is high, so synchronizers and filter come out of reset high.
  always_ff @(posedge clk) begin
    if (rst) begin
      kclk_sync    <= 2'b11;
      kdata_sync   <= 2'b11;
      filt_reg     <= 1'b1;
      filt_cnt_reg <= '0;
    end else begin
      kclk_sync  <= {kclk_sync[0], kclk};
      kdata_sync <= {kdata_sync[0], kdata};
      if (ks == filt_reg) begin
        filt_cnt_reg <= '0;
      end else if (filt_cnt_reg == FW'(FILTER_LEN - 1)) begin
        filt_reg     <= ks;
        filt_cnt_reg <= '0;
      end else begin
        filt_cnt_reg <= filt_cnt_reg + 1'b1;
      end
    end
  end

  assign fall = filt_reg && !ks && (filt_cnt_reg == FW'(FILTER_LEN - 1));

`ifdef PS2_PARITY_CHECK_EN
  assign parity_ok = (^shift_reg) ^ par_reg;
`else
  assign parity_ok = 1'b1;
`endif

  always_comb begin
    state_next   = state_reg;
    bit_cnt_next = bit_cnt_reg;
    shift_next   = shift_reg;
    par_next     = par_reg;
    frame_ok     = 1'b0;
    frame_bad    = 1'b0;
    tmo_next     = (state_reg == IDLE || fall) ? '0 : tmo_reg + 1'b1;
    case (state_reg)
      IDLE: if (fall && !kd) begin
        state_next   = DATA;
        bit_cnt_next = 3'd0;
      end
      DATA: if (fall) begin
        shift_next   = {kd, shift_reg[7:1]};
        bit_cnt_next = bit_cnt_reg + 3'd1;
        if (bit_cnt_reg == 3'd7) state_next = PARITY;
      end
      PARITY: if (fall) begin
        par_next   = kd;
        state_next = STOP;
      end
      STOP: if (fall) begin
        state_next = IDLE;
        if (kd && parity_ok) frame_ok  = 1'b1;
        else                 frame_bad = 1'b1;
      end
      default: state_next = IDLE;
    endcase
    // A stalled clock mid-frame overrides anything decoded this cycle.
    if (state_reg != IDLE && tmo_reg == TW'(TIMEOUT_CYCLES)) begin
      state_next = IDLE;
      frame_ok   = 1'b0;
      frame_bad  = 1'b1;
      tmo_next   = '0;
    end
  end

  always_comb begin
    seq_next   = seq_reg;
    flags_next = flags_reg;
    ext        = (seq_reg == EXT) || (seq_reg == EXT_BRK);
    make       = (seq_reg == BASE) || (seq_reg == EXT);
    if (frame_bad) begin
      seq_next = BASE;
    end else if (frame_ok) begin
      case (shift_reg)
        8'hE0: seq_next = EXT;
        8'hF0: seq_next = ext ? EXT_BRK : BRK;
        default: begin
          seq_next = BASE;
          if (ext) begin
            case (shift_reg)
              8'h6B:   flags_next[4] = make;
              8'h74:   flags_next[3] = make;
              8'h75:   flags_next[2] = make;
              8'h72:   flags_next[1] = make;
              default: ;
            endcase
          end else if (shift_reg == 8'h29) begin
            flags_next[0] = make;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      bit_cnt_reg <= '0;
      shift_reg   <= '0;
      par_reg     <= 1'b0;
      tmo_reg     <= '0;
      seq_reg     <= BASE;
      flags_reg   <= '0;
      scan_code   <= '0;
      scan_valid  <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      bit_cnt_reg <= bit_cnt_next;
      shift_reg   <= shift_next;
      par_reg     <= par_next;
      tmo_reg     <= tmo_next;
      seq_reg     <= seq_next;
      flags_reg   <= flags_next;
      scan_valid  <= frame_ok;
      frame_err   <= frame_bad;
      if (frame_ok) scan_code <= shift_reg;
    end
  end

  assign {key_left, key_right, key_up, key_down, key_space} = flags_reg;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: bit-banged PS/2 frames with hand-computed expectations.
module tb_ps2_key_decoder;
  localparam int TMO  = 2000;
  localparam int HALF = 30;

  logic clk = 1'b0, rst = 1'b1, kclk = 1'b1, kdata = 1'b1;
  logic [7:0] scan_code;
  logic scan_valid, frame_err, key_left, key_right, key_up, key_down, key_space;
  logic [4:0] flags;
  int errors = 0, checks = 0;
  int sv_cnt = 0, fe_cnt = 0, both_cnt = 0;
  int sv0, fe0;

  ps2_key_decoder #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .kclk(kclk), .kdata(kdata),
    .scan_code(scan_code), .scan_valid(scan_valid), .frame_err(frame_err),
    .key_left(key_left), .key_right(key_right), .key_up(key_up),
    .key_down(key_down), .key_space(key_space)
  );

  always #5 clk = ~clk;
  assign flags = {key_left, key_right, key_up, key_down, key_space};

  always @(negedge clk) begin
    if (scan_valid) sv_cnt++;
    if (frame_err) fe_cnt++;
    if (scan_valid && frame_err) both_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    kdata = b;
    repeat (HALF) @(negedge clk);
    kclk = 1'b0;
    repeat (HALF) @(negedge clk);
    kclk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic bad_stop);
    logic p;
    p = (~^d) ^ bad_par;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(p);
    send_bit(~bad_stop);
    kdata = 1'b1;
    repeat (40) @(negedge clk);
    $display("frame %02h bad_par=%0d bad_stop=%0d -> code=%02h flags=%05b", d, bad_par, bad_stop, scan_code, flags);
  endtask

  task automatic snap();
    sv0 = sv_cnt;
    fe0 = fe_cnt;
  endtask

  initial begin
    logic [7:0] d;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("reset_flags", 32'(flags), 32'h0);
    check_eq("reset_code", 32'(scan_code), 32'h0);
    check_eq("reset_valid", 32'(scan_valid), 32'h0);
    check_eq("reset_err", 32'(frame_err), 32'h0);

    snap();
    send_frame(8'h29, 1'b0, 1'b0);
    check_eq("space_code", 32'(scan_code), 32'h29);
    check_eq("space_valid_cnt", 32'(sv_cnt - sv0), 32'd1);
    check_eq("space_make", 32'(key_space), 32'd1);

    snap();
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h29, 1'b0, 1'b0);
    check_eq("space_break", 32'(key_space), 32'd0);
    check_eq("break_valid_cnt", 32'(sv_cnt - sv0), 32'd2);
    check_eq("break_err_cnt", 32'(fe_cnt - fe0), 32'd0);

    send_frame(8'hE0, 1'b0, 1'b0);
    send_frame(8'h6B, 1'b0, 1'b0);
    check_eq("left_make", 32'(flags), 32'b10000);
    send_frame(8'hE0, 1'b0, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h6B, 1'b0, 1'b0);
    check_eq("left_break", 32'(flags), 32'b00000);
    send_frame(8'h6B, 1'b0, 1'b0);
    check_eq("keypad_6b_ignored", 32'(flags), 32'b00000);

    send_frame(8'hE0, 1'b0, 1'b0);
    send_frame(8'h74, 1'b0, 1'b0);
    send_frame(8'hE0, 1'b0, 1'b0);
    send_frame(8'h75, 1'b0, 1'b0);
    check_eq("right_up_held", 32'(flags), 32'b01100);
    send_frame(8'hE0, 1'b0, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h74, 1'b0, 1'b0);
    check_eq("right_released", 32'(flags), 32'b00100);

    snap();
    send_frame(8'h1C, 1'b1, 1'b0);
`ifdef PS2_PARITY_CHECK_EN
    check_eq("badpar_err_cnt", 32'(fe_cnt - fe0), 32'd1);
    check_eq("badpar_valid_cnt", 32'(sv_cnt - sv0), 32'd0);
`else
    check_eq("badpar_valid_cnt", 32'(sv_cnt - sv0), 32'd1);
    check_eq("badpar_code", 32'(scan_code), 32'h1C);
`endif
    check_eq("badpar_flags", 32'(flags), 32'b00100);

    snap();
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    kdata = 1'b1;
    repeat (TMO + 300) @(negedge clk);
    $display("timeout after 4 data bits -> err_pulses=%0d", fe_cnt - fe0);
    check_eq("timeout_err_cnt", 32'(fe_cnt - fe0), 32'd1);
    check_eq("timeout_valid_cnt", 32'(sv_cnt - sv0), 32'd0);
    snap();
    send_frame(8'h29, 1'b0, 1'b0);
    check_eq("post_timeout_code", 32'(scan_code), 32'h29);
    check_eq("post_timeout_flags", 32'(flags), 32'b00101);

    snap();
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h29, 1'b0, 1'b1);
    check_eq("badstop_err_cnt", 32'(fe_cnt - fe0), 32'd1);
    check_eq("badstop_valid_cnt", 32'(sv_cnt - sv0), 32'd1);
    check_eq("badstop_flags_kept", 32'(flags), 32'b00101);

    send_frame(8'hE0, 1'b0, 1'b0);
    send_frame(8'h72, 1'b0, 1'b0);
    check_eq("down_make", 32'(key_down), 32'd1);
    check_eq("no_dual_strobe", 32'(both_cnt), 32'd0);

    d = 8'hE0;
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(d[i]);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("midframe_rst_flags", 32'(flags), 32'h0);
    snap();
    for (int i = 3; i < 8; i++) send_bit(d[i]);
    send_bit((~^d));
    send_bit(1'b1);
    kdata = 1'b1;
    repeat (TMO + 300) @(negedge clk);
    $display("rst mid-frame, remainder sent -> valid_pulses=%0d", sv_cnt - sv0);
    check_eq("midframe_rst_no_valid", 32'(sv_cnt - sv0), 32'd0);
    check_eq("midframe_rst_flags_after", 32'(flags), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
